// File: rtl/dcpu16_mem_slave.sv
// dcpu16_mem_slave: F-BUS/G-BUS arbitrated 2**AW x 16 single-port memory with WAIT wait states.
// Optional boot-ROM write protection of adr >= PROT_BASE: define DCPU16_MEM_WPROT_EN.  Rev 1.0
`default_nettype none

module dcpu16_mem_slave #(
  parameter int          AW        = 16,
  parameter int          WAIT      = 0,
  parameter logic [15:0] PROT_BASE = 16'hF000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] f_adr,
  input  logic        f_stb,
  input  logic        f_wre,
  input  logic [15:0] f_dto,
  output logic [15:0] f_dti,
  output logic        f_ack,
  input  logic [15:0] g_adr,
  input  logic        g_stb,
  input  logic        g_wre,
  input  logic [15:0] g_dto,
  output logic [15:0] g_dti,
  output logic        g_ack
);

`ifdef DCPU16_MEM_WPROT_EN
  localparam bit PROT_EN = 1'b1;
`else
  localparam bit PROT_EN = 1'b0;
`endif

  localparam logic [3:0] CNT_LOAD = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [15:0] mem [0:(2**AW)-1];

  logic        sel_q;
  logic [15:0] adr_q;
  logic        wre_q;
  logic [15:0] dto_q;
  logic [3:0]  cnt_q;
  logic        last_g_q;
  logic        ack_f_q;
  logic        ack_g_q;
  logic [15:0] dti_f_q;
  logic [15:0] dti_g_q;

  logic        grant_any;
  logic        grant_g;
  logic        cur_stb;
  logic        commit;
  logic        c_sel;
  logic [15:0] c_adr;
  logic        c_wre;
  logic [15:0] c_dto;
  logic        prot_hit;
  logic        mem_we;
  logic [15:0] rd_data;

  // On a tie the port that did not win the previous tie is granted.
  always_comb begin
    grant_any = f_stb | g_stb;
    grant_g   = g_stb & (~f_stb | ~last_g_q);
    cur_stb   = sel_q ? g_stb : f_stb;
  end

  // With WAIT==0 the commit happens on the grant edge, so the live bus is used.
  always_comb begin
    if (state == ST_IDLE) begin
      c_sel = grant_g;
      c_adr = grant_g ? g_adr : f_adr;
      c_wre = grant_g ? g_wre : f_wre;
      c_dto = grant_g ? g_dto : f_dto;
    end else begin
      c_sel = sel_q;
      c_adr = adr_q;
      c_wre = wre_q;
      c_dto = dto_q;
    end
    prot_hit = PROT_EN && (c_adr >= PROT_BASE);
    mem_we   = commit & c_wre & rst & ~prot_hit;
    rd_data  = mem[c_adr[AW-1:0]];
  end

  always_comb begin
    state_nxt = state;
    commit    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (grant_any) begin
          if (WAIT == 0) begin
            state_nxt = ST_ACK;
            commit    = 1'b1;
          end else begin
            state_nxt = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (!cur_stb) begin
          state_nxt = ST_IDLE;
        end else if (cnt_q == 4'd0) begin
          state_nxt = ST_ACK;
          commit    = 1'b1;
        end
      end
      ST_ACK: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= ST_IDLE;
      sel_q    <= 1'b0;
      adr_q    <= 16'h0;
      wre_q    <= 1'b0;
      dto_q    <= 16'h0;
      cnt_q    <= 4'd0;
      last_g_q <= 1'b1;
      ack_f_q  <= 1'b0;
      ack_g_q  <= 1'b0;
      dti_f_q  <= 16'h0;
      dti_g_q  <= 16'h0;
    end else begin
      state   <= state_nxt;
      ack_f_q <= commit & ~c_sel;
      ack_g_q <= commit & c_sel;
      if (state == ST_IDLE && grant_any) begin
        sel_q <= grant_g;
        adr_q <= grant_g ? g_adr : f_adr;
        wre_q <= grant_g ? g_wre : f_wre;
        dto_q <= grant_g ? g_dto : f_dto;
        cnt_q <= CNT_LOAD;
        if (f_stb && g_stb) begin
          last_g_q <= ~last_g_q;
        end
      end else if (state == ST_WAIT && cnt_q != 4'd0) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (commit && !c_wre) begin
        if (c_sel) begin
          dti_g_q <= rd_data;
        end else begin
          dti_f_q <= rd_data;
        end
      end
    end
  end

  // The array itself is never reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[c_adr[AW-1:0]] <= c_dto;
    end
  end

  assign f_ack = ack_f_q & f_stb;
  assign g_ack = ack_g_q & g_stb;
  assign f_dti = dti_f_q;
  assign g_dti = dti_g_q;

endmodule

`default_nettype wire

// File: tb/tb_dcpu16_mem_slave.sv
// tb_dcpu16_mem_slave: randomized scoreboard bench for dcpu16_mem_slave (AW=8, WAIT=3).
`default_nettype none

module tb_dcpu16_mem_slave;

  localparam int          AW        = 8;
  localparam int          WAIT      = 3;
  localparam logic [15:0] PROT_BASE = 16'hF000;
  localparam int          SOLO      = WAIT + 2;
  localparam int          PAIR      = 2 * WAIT + 4;
  localparam int          STARVE    = 3 * (WAIT + 2);
  localparam int          TMO       = 60;

`ifdef DCPU16_MEM_WPROT_EN
  localparam bit PROT_ON = 1'b1;
`else
  localparam bit PROT_ON = 1'b0;
`endif

  typedef struct {
    logic [15:0] adr;
    logic        wre;
    logic [15:0] dto;
  } req_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] adr [2];
  logic [15:0] dto [2];
  logic        stb [2];
  logic        wre [2];
  logic [15:0] f_dti;
  logic [15:0] g_dti;
  logic        f_ack;
  logic        g_ack;

  req_t        qf[$];
  req_t        qg[$];
  logic [15:0] mem_m [0:(2**AW)-1];
  logic [15:0] last_m [2];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  dcpu16_mem_slave #(.AW(AW), .WAIT(WAIT), .PROT_BASE(PROT_BASE)) dut (
    .clk   (clk),
    .rst   (rst),
    .f_adr (adr[0]),
    .f_stb (stb[0]),
    .f_wre (wre[0]),
    .f_dto (dto[0]),
    .f_dti (f_dti),
    .f_ack (f_ack),
    .g_adr (adr[1]),
    .g_stb (stb[1]),
    .g_wre (wre[1]),
    .g_dto (dto[1]),
    .g_dti (g_dti),
    .g_ack (g_ack)
  );

  function automatic logic ackp(input int p);
    return (p == 0) ? f_ack : g_ack;
  endfunction

  function automatic logic [15:0] dtip(input int p);
    return (p == 0) ? f_dti : g_dti;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: every ack retires the oldest request of that port, in commit order.
  always @(negedge clk) begin
    if (!rst) begin
      last_m[0] = 16'h0;
      last_m[1] = 16'h0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (ackp(p)) begin
          req_t r;
          if ((p == 0) ? (qf.size() == 0) : (qg.size() == 0)) begin
            checks++;
            errors++;
            $display("FAIL spurious_ack port=%0d actual=1 required=0", p);
          end else begin
            r = (p == 0) ? qf.pop_front() : qg.pop_front();
            chk("ack_needs_stb", 32'(stb[p]), 32'd1);
            if (r.wre) begin
              chk((p == 0) ? "f_dti_hold" : "g_dti_hold", 32'(dtip(p)), 32'(last_m[p]));
              if (!(PROT_ON && r.adr >= PROT_BASE)) begin
                mem_m[r.adr[AW-1:0]] = r.dto;
              end
            end else begin
              chk((p == 0) ? "f_rd_data" : "g_rd_data", 32'(dtip(p)), 32'(mem_m[r.adr[AW-1:0]]));
              last_m[p] = mem_m[r.adr[AW-1:0]];
            end
          end
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 of the cycle after the ack with stb dropped.
  task automatic access(input int p, input logic [15:0] a, input logic w,
                        input logic [15:0] d, output int lat);
    req_t r;
    bit   got;
    r.adr = a;
    r.wre = w;
    r.dto = d;
    if (p == 0) qf.push_back(r);
    else        qg.push_back(r);
    adr[p] = a;
    wre[p] = w;
    dto[p] = d;
    stb[p] = 1'b1;
    lat = 0;
    got = 1'b0;
    while (!got && lat < TMO) begin
      @(negedge clk);
      lat++;
      if (ackp(p)) got = 1'b1;
    end
    @(posedge clk);
    #1;
    stb[p] = 1'b0;
    chk("ack_timeout", 32'(got), 32'd1);
    if (!got) begin
      if (p == 0) void'(qf.pop_back());
      else        void'(qg.pop_back());
    end
  endtask

  task automatic idle(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rnd_port(input int p, input int n);
    int lat;
    for (int i = 0; i < n; i++) begin
      access(p, 16'($urandom), 1'($urandom_range(0, 1)), 16'($urandom), lat);
      chk("starve_bound", 32'(lat <= STARVE), 32'd1);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle(2);
    rst = 1'b1;
  endtask

  initial begin
    int lat;
    int latf;
    int latg;
    int acks;
    for (int p = 0; p < 2; p++) begin
      adr[p] = 16'h0;
      dto[p] = 16'h0;
      stb[p] = 1'b0;
      wre[p] = 1'b0;
      last_m[p] = 16'h0;
    end
    idle(3);
    @(negedge clk);
    chk("rst_f_ack", 32'(f_ack), 32'd0);
    chk("rst_g_ack", 32'(g_ack), 32'd0);
    chk("rst_f_dti", 32'(f_dti), 32'd0);
    chk("rst_g_dti", 32'(g_dti), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle(1);

    // Give every word a known value.
    for (int i = 0; i < 2**AW; i++) access(0, 16'(i), 1'b1, 16'($urandom), lat);

    // Solo latency and write-then-read across ports.
    access(0, 16'h0010, 1'b1, 16'hBEEF, lat);
    chk("solo_lat_f", 32'(lat), 32'(SOLO));
    access(1, 16'h0010, 1'b0, 16'h0, lat);
    chk("solo_lat_g", 32'(lat), 32'(SOLO));
    access(0, 16'h0010, 1'b1, 16'h7777, lat);
    @(negedge clk);
    chk("g_dti_stable", 32'(g_dti), 32'h0000BEEF);
    @(posedge clk);
    #1;

    // Reset lands on the commit edge of a write.
    access(0, 16'h0040, 1'b1, 16'h0BAD, lat);
    access(0, 16'h0040, 1'b0, 16'h0, lat);
    adr[0] = 16'h0040;
    wre[0] = 1'b1;
    dto[0] = 16'hAAAA;
    stb[0] = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(1);
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_f_ack", 32'(f_ack), 32'd0);
    chk("rstmid_g_ack", 32'(g_ack), 32'd0);
    chk("rstmid_f_dti", 32'(f_dti), 32'd0);
    chk("rstmid_g_dti", 32'(g_dti), 32'd0);
    #1;
    stb[0] = 1'b0;
    @(posedge clk);
    #1;
    access(1, 16'h0040, 1'b0, 16'h0, lat);

    // Ties straight out of reset: F first, then G first.
    do_reset();
    fork
      access(0, 16'h0020, 1'b1, 16'h1234, latf);
      access(1, 16'h0020, 1'b0, 16'h0, latg);
    join
    chk("tie1_lat_f", 32'(latf), 32'(SOLO));
    chk("tie1_lat_g", 32'(latg), 32'(PAIR));
    fork
      access(0, 16'h0020, 1'b1, 16'h4321, latf);
      access(1, 16'h0020, 1'b0, 16'h0, latg);
    join
    chk("tie2_lat_g", 32'(latg), 32'(SOLO));
    chk("tie2_lat_f", 32'(latf), 32'(PAIR));
    access(1, 16'h0020, 1'b0, 16'h0, lat);

    // G strobe withdrawn during WAIT: no ack, no effect.
    adr[1] = 16'h0030;
    wre[1] = 1'b1;
    dto[1] = 16'hDEAD;
    stb[1] = 1'b1;
    acks = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (g_ack) acks++;
      @(posedge clk);
      #1;
      if (c == 1) stb[1] = 1'b0;
    end
    chk("abort_no_ack", 32'(acks), 32'd0);
    access(1, 16'h0030, 1'b0, 16'h0, lat);
    access(0, 16'h0030, 1'b1, 16'h5555, lat);
    chk("after_abort_lat", 32'(lat), 32'(SOLO));
    access(1, 16'h0030, 1'b0, 16'h0, lat);

    // Protection boundary (0xF000 aliases word 0 of the array).
    access(0, 16'h0000, 1'b1, 16'h0ABC, lat);
    access(0, 16'hF000, 1'b1, 16'h1111, lat);
    access(1, 16'hF000, 1'b0, 16'h0, lat);
    access(0, 16'hEFFF, 1'b1, 16'h2222, lat);
    access(1, 16'hEFFF, 1'b0, 16'h0, lat);

    fork
      rnd_port(0, 300);
      rnd_port(1, 300);
    join
    idle(5);
    chk("qf_drained", 32'(qf.size()), 32'd0);
    chk("qg_drained", 32'(qg.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
